// File: rtl/max7219_rx.sv
// rtl/max7219_rx.sv - MAX7219-style 3-wire link receiver with shadow register file
// Oversamples sck/cs/din on clock, rebuilds 16-bit frames and decodes register writes.
module max7219_rx #(
  parameter int DIGIT_NUM = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   max_sck,
  input  logic                   max_cs,
  input  logic                   max_din,
  output logic [8*DIGIT_NUM-1:0] digit_data,
  output logic [7:0]             decode_mode,
  output logic [3:0]             intensity,
  output logic [2:0]             scan_limit,
  output logic                   shutdown_n,
  output logic                   display_test,
  output logic                   frame_valid,
  output logic [3:0]             frame_addr,
  output logic [7:0]             frame_data,
  output logic                   frame_err
);

  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_WAIT_CS} state_t;

  state_t state_q, state_d;

  logic sck_s1_q, sck_s2_q, sck_s3_q;
  logic cs_s1_q, cs_s2_q, cs_s3_q;
  logic din_s1_q, din_s2_q;

  logic [15:0] sr_q, sr_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [1:0]  settle_q, settle_d;
  logic        accept, reject;
  logic [3:0]  addr;
  logic [7:0]  data;
  logic        unused_sr_msb;

  logic [8*DIGIT_NUM-1:0] digit_q;
  logic [7:0]             decode_q;
  logic [3:0]             intensity_q;
  logic [2:0]             scan_q;
  logic                   shutdown_n_q;
  logic                   test_q;
  logic                   valid_q;
  logic                   err_q;
  logic [3:0]             addr_q;
  logic [7:0]             data_q;

  wire sck_rise = sck_s2_q & ~sck_s3_q;
  wire cs_fall  = ~cs_s2_q & cs_s3_q;
  wire cs_rise  = cs_s2_q & ~cs_s3_q;

  assign unused_sr_msb = sr_q[15];

  always_ff @(posedge clock) begin
    if (reset) begin
      sck_s1_q <= 1'b0;
      sck_s2_q <= 1'b0;
      sck_s3_q <= 1'b0;
      cs_s1_q  <= 1'b1;
      cs_s2_q  <= 1'b1;
      cs_s3_q  <= 1'b1;
      din_s1_q <= 1'b0;
      din_s2_q <= 1'b0;
    end else begin
      sck_s1_q <= max_sck;
      sck_s2_q <= sck_s1_q;
      sck_s3_q <= sck_s2_q;
      cs_s1_q  <= max_cs;
      cs_s2_q  <= cs_s1_q;
      cs_s3_q  <= cs_s2_q;
      din_s1_q <= max_din;
      din_s2_q <= din_s1_q;
    end
  end

  // Reset lands in WAIT_CS; the settle counter lets the cs pipeline fill with
  // the real pin level before deciding whether the link is idle.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ST_WAIT_CS;
      sr_q     <= 16'h0000;
      cnt_q    <= 5'd0;
      settle_q <= 2'd0;
    end else begin
      state_q  <= state_d;
      sr_q     <= sr_d;
      cnt_q    <= cnt_d;
      settle_q <= settle_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    sr_d     = sr_q;
    cnt_d    = cnt_q;
    settle_d = (settle_q == 2'd3) ? 2'd3 : settle_q + 2'd1;
    accept   = 1'b0;
    reject   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cs_fall) begin
          state_d = ST_SHIFT;
          sr_d    = 16'h0000;
          cnt_d   = 5'd0;
        end
      end
      ST_SHIFT: begin
        // Shift first so a bit arriving with the cs rise is part of the frame.
        if (sck_rise) begin
          sr_d = {sr_q[14:0], din_s2_q};
          if (cnt_q != 5'd16) cnt_d = cnt_q + 5'd1;
        end
        if (cs_rise) begin
          state_d = ST_IDLE;
          if (cnt_d == 5'd16) accept = 1'b1;
          else                reject = 1'b1;
        end
      end
      ST_WAIT_CS: begin
        if (settle_q == 2'd3 && cs_s2_q && cs_s3_q) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign addr = sr_d[11:8];
  assign data = sr_d[7:0];

  always_ff @(posedge clock) begin
    if (reset) begin
      digit_q      <= '0;
      decode_q     <= 8'h00;
      intensity_q  <= 4'h0;
      scan_q       <= 3'd0;
      shutdown_n_q <= 1'b0;
      test_q       <= 1'b0;
      valid_q      <= 1'b0;
      err_q        <= 1'b0;
      addr_q       <= 4'h0;
      data_q       <= 8'h00;
    end else begin
      valid_q <= accept;
      err_q   <= reject;
      if (accept) begin
        addr_q <= addr;
        data_q <= data;
        case (addr)
          4'h9:    decode_q     <= data;
          4'hA:    intensity_q  <= data[3:0];
          4'hB:    scan_q       <= data[2:0];
          4'hC:    shutdown_n_q <= data[0];
          4'hF:    test_q       <= data[0];
          default: ;
        endcase
        for (int k = 0; k < DIGIT_NUM; k++) begin
          if (addr == 4'(k + 1)) digit_q[8*k +: 8] <= data;
        end
      end
    end
  end

  assign digit_data   = digit_q;
  assign decode_mode  = decode_q;
  assign intensity    = intensity_q;
  assign scan_limit   = scan_q;
  assign shutdown_n   = shutdown_n_q;
  assign display_test = test_q;
  assign frame_valid  = valid_q;
  assign frame_addr   = addr_q;
  assign frame_data   = data_q;
  assign frame_err    = err_q;

endmodule

// File: tb/tb_max7219_rx.sv
// tb/tb_max7219_rx.sv - directed bench for max7219_rx
// Two instances (8 and 4 digits) share one link; sck runs at clock/8.
module tb_max7219_rx;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic max_sck = 1'b0;
  logic max_cs = 1'b1;
  logic max_din = 1'b0;

  logic [63:0] d8_digit;
  logic [7:0]  d8_decode;
  logic [3:0]  d8_int;
  logic [2:0]  d8_scan;
  logic        d8_shdn, d8_test, d8_valid, d8_err;
  logic [3:0]  d8_addr;
  logic [7:0]  d8_data;

  logic [31:0] d4_digit;
  logic [7:0]  d4_decode;
  logic [3:0]  d4_int;
  logic [2:0]  d4_scan;
  logic        d4_shdn, d4_test, d4_valid, d4_err;
  logic [3:0]  d4_addr;
  logic [7:0]  d4_data;

  int checks = 0;
  int errors = 0;
  int v8 = 0, e8 = 0, v4 = 0, e4 = 0;

  max7219_rx #(.DIGIT_NUM(8)) dut8 (
    .clock(clock), .reset(reset), .max_sck(max_sck), .max_cs(max_cs), .max_din(max_din),
    .digit_data(d8_digit), .decode_mode(d8_decode), .intensity(d8_int),
    .scan_limit(d8_scan), .shutdown_n(d8_shdn), .display_test(d8_test),
    .frame_valid(d8_valid), .frame_addr(d8_addr), .frame_data(d8_data), .frame_err(d8_err)
  );

  max7219_rx #(.DIGIT_NUM(4)) dut4 (
    .clock(clock), .reset(reset), .max_sck(max_sck), .max_cs(max_cs), .max_din(max_din),
    .digit_data(d4_digit), .decode_mode(d4_decode), .intensity(d4_int),
    .scan_limit(d4_scan), .shutdown_n(d4_shdn), .display_test(d4_test),
    .frame_valid(d4_valid), .frame_addr(d4_addr), .frame_data(d4_data), .frame_err(d4_err)
  );

  always #5 clock = ~clock;

  // Counting high cycles also catches pulses that last longer than one cycle.
  always @(negedge clock) begin
    if (d8_valid) v8++;
    if (d8_err)   e8++;
    if (d4_valid) v4++;
    if (d4_err)   e4++;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [31:0] val, input int nbits, input bit coinc, input int rst_after);
    max_cs = 1'b0;
    tick(4);
    for (int i = nbits - 1; i >= 0; i--) begin
      max_din = val[i];
      max_sck = 1'b0;
      tick(4);
      if (coinc && i == 0) begin
        max_sck = 1'b1;
        max_cs  = 1'b1;
        tick(4);
        max_sck = 1'b0;
        tick(8);
        return;
      end
      max_sck = 1'b1;
      tick(4);
      if (rst_after > 0 && (nbits - i) == rst_after) begin
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
      end
    end
    max_sck = 1'b0;
    tick(4);
    max_cs = 1'b1;
    tick(8);
  endtask

  task automatic frame(input logic [15:0] val);
    send({16'h0000, val}, 16, 1'b0, 0);
  endtask

  initial begin
    tick(3);
    reset = 1'b0;
    tick(10);
    chk("rst_digit", d8_digit, 64'h0);
    chk("rst_int", 64'(d8_int), 64'h0);
    chk("rst_shdn", 64'(d8_shdn), 64'h0);
    chk("rst_addr", 64'(d8_addr), 64'h0);
    chk("rst_pulses", 64'(v8 + e8), 64'h0);

    frame(16'h0A05);
    chk("int5", 64'(d8_int), 64'h5);
    chk("int5_addr", 64'(d8_addr), 64'hA);
    chk("int5_data", 64'(d8_data), 64'h05);
    chk("int5_valid", 64'(v8), 64'd1);
    chk("int5_other", {d8_digit[55:0], d8_decode}, 64'h0);
    chk("int5_scan", 64'({d8_scan, d8_shdn, d8_test}), 64'h0);
    chk("int5_d4", 64'(d4_int), 64'h5);

    frame(16'h0112); frame(16'h0222); frame(16'h0333); frame(16'h0444);
    frame(16'h0555); frame(16'h0666); frame(16'h0777); frame(16'h0889);
    frame(16'h0C01);
    chk("fill_d8", d8_digit, 64'h8977665544332212);
    chk("fill_d4", 64'(d4_digit), 64'h44332212);
    chk("fill_shdn", 64'(d8_shdn), 64'h1);
    chk("fill_valid", 64'(v8), 64'd10);
    chk("fill_valid4", 64'(v4), 64'd10);
    chk("fill_last", 64'({d8_addr, d8_data}), 64'hC01);

    send(32'h0000_0503, 15, 1'b0, 0);
    chk("short_err", 64'(e8), 64'd1);
    chk("short_valid", 64'(v8), 64'd10);
    chk("short_int", 64'(d8_int), 64'h5);

    send(32'h0A0F_0B03, 32, 1'b0, 0);
    chk("long_scan", 64'(d8_scan), 64'h3);
    chk("long_int", 64'(d8_int), 64'h5);
    chk("long_valid", 64'(v8), 64'd11);
    chk("long_err", 64'(e8), 64'd1);

    send(32'h0000_0F01, 16, 1'b1, 0);
    chk("coinc_test", 64'(d8_test), 64'h1);
    chk("coinc_valid", 64'(v8), 64'd12);
    chk("coinc_addr", 64'({d8_addr, d8_data}), 64'hF01);

    send(32'h0000_0A09, 16, 1'b0, 8);
    chk("rstmid_valid", 64'(v8), 64'd12);
    chk("rstmid_err", 64'(e8 + e4), 64'd2);
    chk("rstmid_int", 64'(d8_int), 64'h0);
    chk("rstmid_digit", d8_digit, 64'h0);
    chk("rstmid_flags", 64'({d8_shdn, d8_test}), 64'h0);
    frame(16'h0A09);
    chk("after_int", 64'(d8_int), 64'h9);
    chk("after_valid", 64'(v8), 64'd13);

    frame(16'h0311);
    frame(16'h0677);
    frame(16'h0D55);
    chk("ign_d4_digit", 64'(d4_digit), 64'h00110000);
    chk("ign_d4_regs", 64'({d4_decode, d4_int, d4_scan, d4_shdn, d4_test}), 64'({8'h00, 4'h9, 3'd0, 1'b0, 1'b0}));
    chk("ign_valid4", 64'(v4), 64'd16);
    chk("ign_d8_digit", d8_digit, 64'h0000_7700_0011_0000);
    chk("ign_last4", 64'({d4_addr, d4_data}), 64'hD55);

    frame(16'h0BFF);
    chk("trunc_scan8", 64'(d8_scan), 64'h7);
    chk("trunc_scan4", 64'(d4_scan), 64'h7);
    frame(16'h09A5);
    chk("decode", 64'(d8_decode), 64'hA5);
    chk("final_valid", 64'(v8), 64'd18);
    chk("final_err4", 64'(e4), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/max7219_rx.md
# max7219_rx

Serial receiver for the MAX7219-style 3-wire display link (`max_sck`, `max_cs`, `max_din`). It samples the link with the system clock, reassembles 16-bit frames, and decodes them into a shadow copy of the display-driver register file. It sits on the receiving end of the display interface and serves two purposes:

- as a loopback monitor, so on-chip logic and the bench can check what the calculator display path actually sent;
- as the front end of a second display-controller target.

## Interface

Parameters:
- `DIGIT_NUM`, default 8: number of digit registers shadowed (addresses 1..`DIGIT_NUM`); legal range 1-8.

Ports:
- `clock`, input, 1: system clock. All logic is on its rising edge.
- `reset`, input, 1: one clock; reset is synchronous and active-high.
- `max_sck`, input, 1: serial clock, asynchronous to `clock`. Data is taken on its rising edge.
- `max_cs`, input, 1: chip select, active-low, asynchronous. The frame latches on its rising edge.
- `max_din`, input, 1: serial data, MSB first, asynchronous.
- `digit_data`, output, 8*`DIGIT_NUM`: digit registers. Digit k occupies bits [8k+7:8k] and is written by address k+1.
- `decode_mode`, output, 8: register at address 0x9.
- `intensity`, output, 4: register at address 0xA, low nibble.
- `scan_limit`, output, 3: register at address 0xB, low 3 bits.
- `shutdown_n`, output, 1: register at address 0xC, bit 0. A value of 0 means shutdown.
- `display_test`, output, 1: register at address 0xF, bit 0.
- `frame_valid`, output, 1: one-cycle pulse when a frame is accepted.
- `frame_addr`, output, 4: address of the last accepted frame.
- `frame_data`, output, 8: data of the last accepted frame.
- `frame_err`, output, 1: one-cycle pulse when a frame is rejected (fewer than 16 bits).

## Operation

- **Synchronizers:** each of `max_sck`, `max_cs` and `max_din` passes through a 2-flop synchronizer. Edge detection then uses a third registered copy of `sck` and `cs`.
- **States:**
  - IDLE (`cs` high).
  - SHIFT (`cs` low, armed).
  - WAIT_CS (`cs` low, not armed; entered when `reset` deasserts while `cs` is low).
- **Transitions:**
  - IDLE to SHIFT on a `cs` falling edge. On entry, the 16-bit shift register and the bit counter are cleared.
  - SHIFT to IDLE on a `cs` rising edge, with frame evaluation.
  - WAIT_CS to IDLE on a `cs` rising edge, with no evaluation and no pulses.
- **Shifting in SHIFT:** on each synced `sck` rising edge, the shift register becomes {sr[14:0], din_sync}. The bit counter increments and saturates at 16.
- **Edges outside SHIFT:** `sck` edges in IDLE or WAIT_CS are ignored.
- **Frame evaluation on `cs` rise:**
  - Counter below 16: `frame_err` pulses and no register changes.
  - Counter at 16: the frame is accepted and uses the last 16 bits shifted. Longer frames (daisy-chain pass-through) are accepted the same way.
- **Accepted frame:**
  - Address is sr[11:8] and data is sr[7:0]. Bits sr[15:12] are ignored.
  - `frame_addr` and `frame_data` are updated and `frame_valid` pulses.
  - The addressed register is written.
- **Address decode:**
  - 0x0 (no-op) writes no register but still pulses `frame_valid`.
  - Addresses 1..`DIGIT_NUM` write `digit_data`. Digit addresses above `DIGIT_NUM` and 0x8 (when `DIGIT_NUM`<8), 0xD and 0xE write nothing but still pulse `frame_valid`.
  - Width truncation: intensity takes data[3:0], scan limit takes data[2:0], shutdown and display test take data[0].
- **Simultaneous `sck` and `cs` rise:** if a `sck` rising edge and a `cs` rising edge are detected in the same cycle, the bit is shifted in and counted before the frame is evaluated.
- **Simultaneous `cs` fall and `sck` rise:** if a `cs` falling edge and a `sck` rising edge coincide, the clear takes priority and the bit is dropped.
- **Reset:**
  - All outputs go to 0: all digits, `decode_mode`, `intensity`, `scan_limit`, `shutdown_n` (i.e. shutdown), `display_test`, both pulses, `frame_addr` and `frame_data`.
  - Synchronizers and edge-detect copies reset high for `cs` and low for `sck` and `din`.
  - A frame in progress is discarded. If `cs` is low when reset deasserts, the block enters WAIT_CS.

## Timing

- **Input to shift register:** 3 `clock` cycles from a `max_sck` transition at the pin to the bit being in the shift register (2 sync stages plus edge detect).
- **`cs` rise to outputs:**
  - `frame_valid` or `frame_err` is asserted during cycle 4 after the `max_cs` rising transition.
  - Register outputs update on the same clock edge that raises `frame_valid`.
  - Each pulse lasts exactly 1 cycle.
- **Link requirements:** `sck` high and low times are each at least 3 `clock` periods. `din` is stable for at least 3 `clock` periods around each `sck` rise. `cs` high time between frames is at least 3 `clock` periods. Behaviour outside these limits is undefined.
- **Throughput:** back-to-back frames are accepted with no dead cycles beyond the `cs` high time.
- All outputs are registered.

## Test plan

- **Intensity write:** reset, then send frame 0x0A05 (sck = clock/8). Expect `intensity`=5, one `frame_valid` with `frame_addr`=0xA and `frame_data`=0x05, and all other registers still 0.
- **Digit fill:** send 0x0112 through 0x0889, then 0x0C01. Expect `digit_data`=0x8977665544332212 (digit 0 = 0x12, digit 7 = 0x89), `shutdown_n`=1, and 9 `frame_valid` pulses.
- **Short and long frames:**
  - 15-bit frame 0x0A07 with the LSB omitted: expect `frame_err` pulse, no `frame_valid`, `intensity` unchanged.
  - 32-bit frame 0x0A0F_0B03: expect `scan_limit`=3, `intensity` unchanged, a single `frame_valid`.
- **Coincident `sck` and `cs` rise:** drive the final `sck` rise in the same `clock` cycle as the `cs` rise, with frame 0x0F01. Expect `display_test`=1 and `frame_valid`.
- **Reset mid-frame:** assert `reset` after bit 8 of frame 0x0A09 while `cs` stays low, then finish clocking bits and raise `cs`. Expect no pulses and `intensity`=0. The next full frame 0x0A09 gives `intensity`=9.
- **Ignored addresses:**
  - With `DIGIT_NUM`=4, frames 0x0677 and 0x0D55: expect two `frame_valid` pulses and no register change.
  - `scan_limit` truncation: frame 0x0BFF gives `scan_limit`=7.
